// File: rtl/valve_step_sequencer.sv
// Step-table driven valve/pump sequencer.
// The host loads a table of {valve mask, pump enable, dwell, last} entries while
// idle; a start pulse plays the table from entry 0, holding each step for dwell+1
// cycles and rotating a 3-phase peristaltic pattern on p while the step's pump
// bit is set. Outside RUN every line sits in the safe (all-closed) state.
module valve_step_sequencer #(
    parameter int N_VALVE  = 13,
    parameter int STEPS    = 16,
    parameter int DWELL_W  = 16,
    parameter int PUMP_DIV = 8,
    localparam int AW      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [N_VALVE-1:0] prog_valve,
    input  logic               prog_pump,
    input  logic [DWELL_W-1:0] prog_dwell,
    input  logic               prog_last,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      step_idx,
    output logic [N_VALVE-1:0] c,
    output logic [2:0]         p
);

    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PUMP_DIV - 1);
    localparam logic [AW-1:0]    PTR_LAST = AW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [1:0]           phase_q, phase_d;
    logic [DIV_W-1:0]     div_q, div_d;

    logic [N_VALVE-1:0]   tbl_valve_q [STEPS];
    logic                 tbl_pump_q  [STEPS];
    logic [DWELL_W-1:0]   tbl_dwell_q [STEPS];
    logic                 tbl_last_q  [STEPS];

    logic [AW-1:0]        ptr_nxt;
    logic                 pump_on;

    // Map a pump phase to its line pattern: exactly one pump valve open.
    function automatic logic [2:0] pump_pattern(input logic [1:0] ph);
        case (ph)
            2'd0:    pump_pattern = 3'b110;
            2'd1:    pump_pattern = 3'b101;
            default: pump_pattern = 3'b011;
        endcase
    endfunction

    // Step table: cleared to a safe single-step program on reset, writable only when not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_valve_q[i] <= '1;
                tbl_pump_q[i]  <= 1'b0;
                tbl_dwell_q[i] <= '0;
                tbl_last_q[i]  <= 1'b1;
            end
        end else if (prog_we && (state_q != S_RUN)) begin
            tbl_valve_q[prog_addr] <= prog_valve;
            tbl_pump_q[prog_addr]  <= prog_pump;
            tbl_dwell_q[prog_addr] <= prog_dwell;
            tbl_last_q[prog_addr]  <= prog_last;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            dwell_q <= '0;
            phase_q <= 2'd0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            phase_q <= phase_d;
            div_q   <= div_d;
        end
    end

    assign ptr_nxt = ptr_q + AW'(1);
    assign pump_on = (state_q == S_RUN) && tbl_pump_q[ptr_q];

    // Next-state: step sequencing with dwell countdown, plus pump phase rotation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        phase_d = 2'd0;
        div_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    dwell_d = tbl_dwell_q[0];
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else if (dwell_q == '0) begin
                    if (tbl_last_q[ptr_q] || (ptr_q == PTR_LAST)) begin
                        state_d = S_DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d   = ptr_nxt;
                        dwell_d = tbl_dwell_q[ptr_nxt];
                    end
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase

        // Rotation only advances while the driven step pumps; it carries across
        // consecutive pumping steps and falls back to phase 0 otherwise.
        if (pump_on) begin
            if (div_q == DIV_MAX) begin
                div_d   = '0;
                phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            end else begin
                div_d   = div_q + DIV_W'(1);
                phase_d = phase_q;
            end
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign step_idx = ptr_q;
    assign c        = busy ? tbl_valve_q[ptr_q] : '1;
    assign p        = pump_on ? pump_pattern(phase_q) : 3'b111;

endmodule

// File: tb/tb_valve_step_sequencer.sv
// Directed bench for valve_step_sequencer (PUMP_DIV = 2).
module tb_valve_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [12:0] prog_valve;
    logic        prog_pump;
    logic [15:0] prog_dwell;
    logic        prog_last;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [3:0]  step_idx;
    logic [12:0] c;
    logic [2:0]  p;

    int checks = 0;
    int errors = 0;

    valve_step_sequencer #(
        .N_VALVE (13),
        .STEPS   (16),
        .DWELL_W (16),
        .PUMP_DIV(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_valve(prog_valve),
        .prog_pump (prog_pump),
        .prog_dwell(prog_dwell),
        .prog_last (prog_last),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .c         (c),
        .p         (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic [12:0] c;
        logic [2:0]  p;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
    } vec_t;

    vec_t tbl [7];

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [12:0] ec, input logic [2:0] ep,
                           input logic eb, input logic ed, input logic [3:0] ei);
        chk({nm, ".c"},    {19'd0, c},        {19'd0, ec});
        chk({nm, ".p"},    {29'd0, p},        {29'd0, ep});
        chk({nm, ".busy"}, {31'd0, busy},     {31'd0, eb});
        chk({nm, ".done"}, {31'd0, done},     {31'd0, ed});
        chk({nm, ".idx"},  {28'd0, step_idx}, {28'd0, ei});
    endtask

    task automatic prog(input logic [3:0] a, input logic [12:0] v, input logic pu,
                        input logic [15:0] d, input logic l);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_valve = v;
        prog_pump  = pu;
        prog_dwell = d;
        prog_last  = l;
        tick();
        prog_we    = 1'b0;
    endtask

    // Advance until done is seen, bounded; an expired bound counts as a failure.
    task automatic wait_done(input string nm, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk({nm, ".done_seen"}, {31'd0, done}, 32'd1);
    endtask

    logic [2:0] pat [3];

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_valve = '0;
        prog_pump = 1'b0; prog_dwell = '0; prog_last = 1'b0;
        start = 1'b0; abort = 1'b0;
        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

        // Reset, then idle 5 cycles.
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk_all("reset", 13'h1FFF, 3'b111, 1'b0, 1'b0, 4'd0);

        // Two-step program; first vector has start+abort together (abort wins).
        prog(4'd0, 13'h1FFD, 1'b0, 16'd2, 1'b0);
        prog(4'd1, 13'h0FFF, 1'b0, 16'd0, 1'b1);
        tbl[0] = '{1'b1, 1'b1, 13'h1FFF, 3'b111, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 13'h1FFD, 3'b111, 1'b1, 1'b0, 4'd0};
        tbl[2] = '{1'b0, 1'b0, 13'h1FFD, 3'b111, 1'b1, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 1'b0, 13'h1FFD, 3'b111, 1'b1, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 1'b0, 13'h0FFF, 3'b111, 1'b1, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 1'b0, 13'h1FFF, 3'b111, 1'b0, 1'b1, 4'd0};
        tbl[6] = '{1'b0, 1'b0, 13'h1FFF, 3'b111, 1'b0, 1'b0, 4'd0};
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            tick();
            chk_all($sformatf("seq2[%0d]", i), tbl[i].c, tbl[i].p, tbl[i].busy, tbl[i].done, tbl[i].idx);
        end
        start = 1'b0; abort = 1'b0;

        // Pump rotation: one 12-cycle pumping step.
        prog(4'd0, 13'h1FFF, 1'b1, 16'd11, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("pump[%0d]", i), {29'd0, p}, {29'd0, pat[(i / 2) % 3]});
            tick();
        end
        chk_all("pump_done", 13'h1FFF, 3'b111, 1'b0, 1'b1, 4'd0);
        tick();

        // Four-step program, abort during step 2.
        prog(4'd0, 13'h1FFE, 1'b0, 16'd1, 1'b0);
        prog(4'd1, 13'h1FFD, 1'b0, 16'd1, 1'b0);
        prog(4'd2, 13'h1FFB, 1'b0, 16'd1, 1'b0);
        prog(4'd3, 13'h1FF7, 1'b0, 16'd1, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk_all("pre_abort", 13'h1FFB, 3'b111, 1'b1, 1'b0, 4'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk_all("abort", 13'h1FFF, 3'b111, 1'b0, 1'b0, 4'd0);
        tick();
        chk("abort_no_done", {31'd0, done}, 32'd0);

        // Rerun from step 0; write and start while busy are ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk_all("rerun0", 13'h1FFE, 3'b111, 1'b1, 1'b0, 4'd0);
        prog_we = 1'b1; prog_addr = 4'd0; prog_valve = 13'h0000;
        prog_pump = 1'b0; prog_dwell = 16'd0; prog_last = 1'b1;
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        chk("busy_idx0", {28'd0, step_idx}, 32'd0);
        tick();
        chk("busy_idx1", {28'd0, step_idx}, 32'd1);
        wait_done("rerun", 20);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk_all("entry0_kept", 13'h1FFE, 3'b111, 1'b1, 1'b0, 4'd0);
        abort = 1'b1; tick(); abort = 1'b0;

        // Sixteen one-cycle steps with implicit end at the last entry.
        for (int i = 0; i < 16; i++)
            prog(4'(i), 13'h1000 | 13'(i), 1'b0, 16'd0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_all($sformatf("s16[%0d]", i), 13'h1000 | 13'(i), 3'b111, 1'b1, 1'b0, 4'(i));
            tick();
        end
        chk_all("s16_done", 13'h1FFF, 3'b111, 1'b0, 1'b1, 4'd0);
        tick();

        // Reset mid-run clears the table.
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("mid_idx", {28'd0, step_idx}, 32'd5);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_all("rst_mid", 13'h1FFF, 3'b111, 1'b0, 1'b0, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk_all("cleared_run", 13'h1FFF, 3'b111, 1'b1, 1'b0, 4'd0);
        tick();
        chk_all("cleared_done", 13'h1FFF, 3'b111, 1'b0, 1'b1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
